// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline and its hazard/stall sequencer.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_IF;
  logic [4:0]       rs2_IF;
  logic             uses_rs1;
  logic             uses_rs2;
  logic [4:0]       rd_ID;
  logic             RegWrite_ID;
  logic [1:0]       ResultSrc_ID;
  logic             isMD_ID;
  logic             redirect_EX;
  logic             md_done;
  logic             Stall_PC;
  logic             Stall_IFID;
  logic             Stall_IDEX;
  logic             Flush_IFID;
  logic             Flush;
  logic             md_start;
  logic             md_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_IF, rs2_IF, uses_rs1, uses_rs2, rd_ID, RegWrite_ID, ResultSrc_ID,
           isMD_ID, redirect_EX, md_done,
    input  Stall_PC, Stall_IFID, Stall_IDEX, Flush_IFID, Flush, md_start, md_err,
           state, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_IF, rs2_IF, uses_rs1, uses_rs2, rd_ID, RegWrite_ID, ResultSrc_ID,
           isMD_ID, redirect_EX, md_done,
    output Stall_PC, Stall_IFID, Stall_IDEX, Flush_IFID, Flush, md_start, md_err,
           state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall sequencer: load-use bubbles, redirect squashes, mul/div waits.
// Define HAZARD_CTRL_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int            TW       = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MD_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = '1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          md_err_q, md_err_d;

  logic load_use;
  logic hit_rs1, hit_rs2;
  logic stall_pc, stall_ifid, stall_idex;
  logic flush_ifid, flush_idex, md_start;

  always_comb begin
    hit_rs1  = hz.uses_rs1 && (hz.rs1_IF == hz.rd_ID);
    hit_rs2  = hz.uses_rs2 && (hz.rs2_IF == hz.rd_ID);
    load_use = hz.RegWrite_ID && (hz.ResultSrc_ID == 2'b01) && (hz.rd_ID != 5'd0)
               && (hit_rs1 || hit_rs2);
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    md_err_d   = md_err_q;
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    stall_idex = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    md_start   = 1'b0;

    case (state_q)
      RUN: begin
        if (hz.isMD_ID) begin
          md_start   = 1'b1;
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          tmo_d      = '0;
          state_d    = MD_WAIT;
        end else if (hz.redirect_EX) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (load_use) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end
      end
      MD_WAIT: begin
        if (hz.md_done) begin
          state_d = RUN;
        end else if (tmo_q == TMO_LAST) begin
          // abort: let the stuck instruction retire and flag it
          md_err_d = 1'b1;
          state_d  = RUN;
        end else begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          if (tmo_q != TMO_MAX) tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = RUN;
    endcase

    flush_ifid = flush_ifid & ~stall_ifid;
    flush_idex = flush_idex & ~stall_idex;

    // while in reset the downstream registers are fed a bubble
    if (rst) begin
      stall_pc   = 1'b0;
      stall_ifid = 1'b0;
      stall_idex = 1'b0;
      md_start   = 1'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      tmo_q    <= '0;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      md_err_q <= md_err_d;
    end
  end

  assign hz.Stall_PC   = stall_pc;
  assign hz.Stall_IFID = stall_ifid;
  assign hz.Stall_IDEX = stall_idex;
  assign hz.Flush_IFID = flush_ifid;
  assign hz.Flush      = flush_idex;
  assign hz.md_start   = md_start;
  assign hz.md_err     = md_err_q;
  assign hz.state      = state_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (stall_pc ? CNT_W'(1) : CNT_W'(0));
    flush_cnt_d = flush_cnt_q + (flush_idex ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
